// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: segment indices, segment masks,
// FSM encoding, forwarding selects and the RAW match helper.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned SEG_PC    = 0;
  localparam int unsigned SEG_IFID  = 1;
  localparam int unsigned SEG_IDEX  = 2;
  localparam int unsigned SEG_EXMEM = 3;
  localparam int unsigned SEG_MEMWB = 4;
  localparam int unsigned NUM_SEG   = 5;

  localparam int unsigned REG_W = 6;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDivw  = 2'd1,
    StXpend = 2'd2
  } state_e;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_EX  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b11;

  localparam logic [NUM_SEG-1:0] M_PC    = NUM_SEG'(1 << SEG_PC);
  localparam logic [NUM_SEG-1:0] M_IFID  = NUM_SEG'(1 << SEG_IFID);
  localparam logic [NUM_SEG-1:0] M_IDEX  = NUM_SEG'(1 << SEG_IDEX);
  localparam logic [NUM_SEG-1:0] M_EXMEM = NUM_SEG'(1 << SEG_EXMEM);
  localparam logic [NUM_SEG-1:0] M_MEMWB = NUM_SEG'(1 << SEG_MEMWB);

  localparam logic [NUM_SEG-1:0] STALL_DBUS = M_PC | M_IFID | M_IDEX | M_EXMEM;
  localparam logic [NUM_SEG-1:0] STALL_DIV  = M_PC | M_IFID | M_IDEX;
  localparam logic [NUM_SEG-1:0] STALL_LOAD = M_PC | M_IFID;
  localparam logic [NUM_SEG-1:0] STALL_IBUS = M_PC;

  localparam logic [NUM_SEG-1:0] FLUSH_EXCP = M_IFID | M_IDEX | M_EXMEM | M_MEMWB;
  localparam logic [NUM_SEG-1:0] FLUSH_DBUS = M_MEMWB;
  localparam logic [NUM_SEG-1:0] FLUSH_DIV  = M_EXMEM;
  localparam logic [NUM_SEG-1:0] FLUSH_LOAD = M_IDEX;
  localparam logic [NUM_SEG-1:0] FLUSH_IBUS = M_IFID;

  function automatic logic raw_hit(input logic             regwen,
                                   input logic [REG_W-1:0] wreg,
                                   input logic [REG_W-1:0] src,
                                   input logic             used);
    return regwen && (wreg == src) && (src != REG_ZERO) && used;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational RAW detection and ID operand forwarding selects.
// HAZARD_FWD_EN enables forwarding; otherwise every RAW stalls like a load-use.
module hazard_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_rs_used_i,
  input  logic             id_rt_used_i,
  input  logic             ex_regwen_i,
  input  logic [REG_W-1:0] ex_wreg_i,
  input  logic             ex_load_i,
  input  logic             mem_regwen_i,
  input  logic [REG_W-1:0] mem_wreg_i,
  input  logic             wb_regwen_i,
  input  logic [REG_W-1:0] wb_wreg_i,
  output logic             hazard_o,
  output fwd_sel_t         fwd_rs_o,
  output fwd_sel_t         fwd_rt_o
);

  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt, load_use;

  assign ex_rs  = raw_hit(ex_regwen_i, ex_wreg_i, id_rs_i, id_rs_used_i);
  assign ex_rt  = raw_hit(ex_regwen_i, ex_wreg_i, id_rt_i, id_rt_used_i);
  assign mem_rs = raw_hit(mem_regwen_i, mem_wreg_i, id_rs_i, id_rs_used_i);
  assign mem_rt = raw_hit(mem_regwen_i, mem_wreg_i, id_rt_i, id_rt_used_i);
  assign wb_rs  = raw_hit(wb_regwen_i, wb_wreg_i, id_rs_i, id_rs_used_i);
  assign wb_rt  = raw_hit(wb_regwen_i, wb_wreg_i, id_rt_i, id_rt_used_i);

  assign load_use = ex_load_i && (ex_rs || ex_rt);

`ifdef HAZARD_FWD_EN
  // Nearest producer wins; a load in EX has no data yet, so it stalls instead.
  function automatic fwd_sel_t pick(input logic ex, input logic mem, input logic wb,
                                    input logic ex_load);
    if (ex)       return ex_load ? FWD_REG : FWD_EX;
    else if (mem) return FWD_MEM;
    else if (wb)  return FWD_WB;
    return FWD_REG;
  endfunction

  assign hazard_o = load_use;
  assign fwd_rs_o = pick(ex_rs, mem_rs, wb_rs, ex_load_i);
  assign fwd_rt_o = pick(ex_rt, mem_rt, wb_rt, ex_load_i);
`else
  assign hazard_o = load_use || ex_rs || ex_rt || mem_rs || mem_rt || wb_rs || wb_rt;
  assign fwd_rs_o = FWD_REG;
  assign fwd_rt_o = FWD_REG;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline controller: per-segment stall/flush, divide sequencing, exception
// redirect. Optional operand forwarding under HAZARD_FWD_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               ex_regwen,
  input  logic [REG_W-1:0]   ex_wreg,
  input  logic               ex_load,
  input  logic               ex_is_div,
  input  logic               mem_regwen,
  input  logic [REG_W-1:0]   mem_wreg,
  input  logic               wb_regwen,
  input  logic [REG_W-1:0]   wb_wreg,
  input  logic               ibus_stall,
  input  logic               dbus_stall,
  input  logic               mem_excp,
  output logic [NUM_SEG-1:0] stall,
  output logic [NUM_SEG-1:0] flush,
  output logic               pc_redirect,
  output logic               div_go,
  output logic               div_cancel,
  output logic [1:0]         fwd_rs,
  output logic [1:0]         fwd_rt
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DIV_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_ok_q, div_ok_d;

  logic     hazard;
  fwd_sel_t fwd_rs_u, fwd_rt_u;

  hazard_fwd_unit u_hazard_fwd_unit (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_rs_used_i (id_rs_used),
    .id_rt_used_i (id_rt_used),
    .ex_regwen_i  (ex_regwen),
    .ex_wreg_i    (ex_wreg),
    .ex_load_i    (ex_load),
    .mem_regwen_i (mem_regwen),
    .mem_wreg_i   (mem_wreg),
    .wb_regwen_i  (wb_regwen),
    .wb_wreg_i    (wb_wreg),
    .hazard_o     (hazard),
    .fwd_rs_o     (fwd_rs_u),
    .fwd_rt_o     (fwd_rt_u)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_ok_d    = div_ok_q;
    stall       = '0;
    flush       = '0;
    pc_redirect = 1'b0;
    div_go      = 1'b0;
    div_cancel  = 1'b0;
    fwd_rs      = fwd_rs_u;
    fwd_rt      = fwd_rt_u;

    unique case (state_q)
      StRun: begin
        if (mem_excp) begin
          flush       = FLUSH_EXCP;
          pc_redirect = 1'b1;
          div_ok_d    = 1'b0;
          state_d     = ibus_stall ? StXpend : StRun;
        end else if (dbus_stall) begin
          stall = STALL_DBUS;
          flush = FLUSH_DBUS;
        end else if (ex_is_div && !div_ok_q) begin
          div_go  = 1'b1;
          stall   = STALL_DIV;
          flush   = FLUSH_DIV;
          cnt_d   = CntLoad;
          state_d = StDivw;
        end else if (hazard) begin
          stall = STALL_LOAD;
          flush = FLUSH_LOAD;
        end else if (ibus_stall) begin
          stall = STALL_IBUS;
          flush = FLUSH_IBUS;
        end
      end
      StDivw: begin
        if (mem_excp) begin
          div_cancel  = 1'b1;
          flush       = FLUSH_EXCP;
          pc_redirect = 1'b1;
          cnt_d       = '0;
          div_ok_d    = 1'b0;
          state_d     = ibus_stall ? StXpend : StRun;
        end else if (cnt_q == '0) begin
          // Result is ready: let EX advance unless MEM is still busy.
          div_ok_d = 1'b1;
          state_d  = StRun;
          if (dbus_stall) begin
            stall = STALL_DBUS;
            flush = FLUSH_DBUS;
          end
        end else begin
          stall = STALL_DIV;
          flush = FLUSH_DIV;
          cnt_d = cnt_q - 1'b1;
        end
      end
      StXpend: begin
        pc_redirect = 1'b1;
        flush       = FLUSH_EXCP;
        state_d     = ibus_stall ? StXpend : StRun;
      end
      default: state_d = StRun;
    endcase

    // Once EX advances in RUN the completed divide has left; arm for the next one.
    if (state_q == StRun && !stall[SEG_IDEX]) begin
      div_ok_d = 1'b0;
    end

    if (!resetn) begin
      stall       = '0;
      flush       = '0;
      pc_redirect = 1'b0;
      div_go      = 1'b0;
      div_cancel  = 1'b0;
      fwd_rs      = FWD_REG;
      fwd_rt      = FWD_REG;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      div_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_ok_q <= div_ok_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with DIV_LAT=4.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       resetn;
  logic [5:0] id_rs, id_rt, ex_wreg, mem_wreg, wb_wreg;
  logic       id_rs_used, id_rt_used, ex_regwen, ex_load, ex_is_div;
  logic       mem_regwen, wb_regwen, ibus_stall, dbus_stall, mem_excp;
  logic [4:0] stall, flush;
  logic       pc_redirect, div_go, div_cancel;
  logic [1:0] fwd_rs, fwd_rt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(
    .DIV_LAT (4),
    .CNT_W   (6)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .ex_regwen   (ex_regwen),
    .ex_wreg     (ex_wreg),
    .ex_load     (ex_load),
    .ex_is_div   (ex_is_div),
    .mem_regwen  (mem_regwen),
    .mem_wreg    (mem_wreg),
    .wb_regwen   (wb_regwen),
    .wb_wreg     (wb_wreg),
    .ibus_stall  (ibus_stall),
    .dbus_stall  (dbus_stall),
    .mem_excp    (mem_excp),
    .stall       (stall),
    .flush       (flush),
    .pc_redirect (pc_redirect),
    .div_go      (div_go),
    .div_cancel  (div_cancel),
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {stall, flush, pc_redirect, div_go, div_cancel, fwd_rs, fwd_rt}.
  function automatic logic [16:0] ev(input logic [4:0] s, input logic [4:0] f,
                                     input logic p, input logic g, input logic c,
                                     input logic [1:0] rs, input logic [1:0] rt);
    return {s, f, p, g, c, rs, rt};
  endfunction

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (stall,flush,pcr,go,cancel,fwd_rs,fwd_rt)",
               tag, got, exp);
    end
  endtask

  task automatic sample(input string tag, input logic [16:0] exp);
    #1;
    check_eq(tag, {stall, flush, pc_redirect, div_go, div_cancel, fwd_rs, fwd_rt}, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
    ex_regwen = 0; ex_wreg = '0; ex_load = 0; ex_is_div = 0;
    mem_regwen = 0; mem_wreg = '0; wb_regwen = 0; wb_wreg = '0;
    ibus_stall = 0; dbus_stall = 0; mem_excp = 0;
  endtask

  localparam logic [16:0] ZERO   = 17'd0;
  localparam logic [4:0]  S_DIV  = 5'b00111;
  localparam logic [4:0]  F_DIV  = 5'b01000;
  localparam logic [4:0]  S_LD   = 5'b00011;
  localparam logic [4:0]  F_LD   = 5'b00100;
  localparam logic [4:0]  F_XP   = 5'b11110;

  initial begin
    idle();
    resetn = 1'b0;
    #2;
    sample("reset", ZERO);
    #8 resetn = 1'b1;
    tick();
    sample("idle", ZERO);

    // Load-use on rs.
    ex_load = 1; ex_regwen = 1; ex_wreg = 6'd5; id_rs = 6'd5; id_rs_used = 1;
    sample("load_use", ev(S_LD, F_LD, 0, 0, 0, 2'b00, 2'b00));
    tick();
    ex_load = 0;
`ifdef HAZARD_FWD_EN
    sample("ex_fwd", ev(5'b0, 5'b0, 0, 0, 0, 2'b01, 2'b00));
`else
    sample("ex_raw", ev(S_LD, F_LD, 0, 0, 0, 2'b00, 2'b00));
`endif
    tick();
    ex_regwen = 0; mem_regwen = 1; mem_wreg = 6'd5;
`ifdef HAZARD_FWD_EN
    sample("mem_fwd", ev(5'b0, 5'b0, 0, 0, 0, 2'b10, 2'b00));
`else
    sample("mem_raw", ev(S_LD, F_LD, 0, 0, 0, 2'b00, 2'b00));
`endif
    tick();
    idle();
    ex_regwen = 1; ex_load = 1; ex_wreg = 6'd0; id_rs = 6'd0; id_rs_used = 1;
    sample("reg_zero", ZERO);
    tick();
    ex_wreg = 6'd5; id_rs = 6'd5; id_rs_used = 0;
    sample("unused_src", ZERO);

    // Priority: dbus over load-use over ibus.
    tick();
    id_rs_used = 1; dbus_stall = 1; ibus_stall = 1;
    sample("prio_dbus", ev(5'b01111, 5'b10000, 0, 0, 0, 2'b00, 2'b00));
    tick();
    dbus_stall = 0;
    sample("prio_load", ev(S_LD, F_LD, 0, 0, 0, 2'b00, 2'b00));
    tick();
    ex_regwen = 0; ex_load = 0;
    sample("prio_ibus", ev(5'b00001, 5'b00010, 0, 0, 0, 2'b00, 2'b00));

    // WB producer on rt.
    tick();
    idle();
    wb_regwen = 1; wb_wreg = 6'd7; id_rt = 6'd7; id_rt_used = 1;
`ifdef HAZARD_FWD_EN
    sample("wb_fwd", ev(5'b0, 5'b0, 0, 0, 0, 2'b00, 2'b11));
`else
    sample("wb_raw", ev(S_LD, F_LD, 0, 0, 0, 2'b00, 2'b00));
`endif

    // Divide, DIV_LAT=4: go, three more held cycles, release, no restart.
    tick();
    idle();
    ex_is_div = 1;
    sample("div_go", ev(S_DIV, F_DIV, 0, 1, 0, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++) begin
      tick();
      sample("div_wait", ev(S_DIV, F_DIV, 0, 0, 0, 2'b00, 2'b00));
    end
    tick();
    sample("div_done", ZERO);
    tick();
    sample("div_hold", ZERO);

    // Exception on the second DIVW cycle.
    tick();
    sample("div2_go", ev(S_DIV, F_DIV, 0, 1, 0, 2'b00, 2'b00));
    tick();
    sample("div2_w1", ev(S_DIV, F_DIV, 0, 0, 0, 2'b00, 2'b00));
    tick();
    mem_excp = 1;
    sample("div_cancel", ev(5'b0, F_XP, 1, 0, 1, 2'b00, 2'b00));
    tick();
    mem_excp = 0;
    sample("post_cancel_go", ev(S_DIV, F_DIV, 0, 1, 0, 2'b00, 2'b00));

    // Asynchronous reset in the middle of DIVW with the divide still requested.
    tick();
    sample("div3_w1", ev(S_DIV, F_DIV, 0, 0, 0, 2'b00, 2'b00));
    resetn = 1'b0;
    sample("rst_async", ZERO);
    resetn = 1'b1;
    sample("rst_go", ev(S_DIV, F_DIV, 0, 1, 0, 2'b00, 2'b00));
    tick();
    sample("rst_div_w", ev(S_DIV, F_DIV, 0, 0, 0, 2'b00, 2'b00));
    tick();
    tick();
    tick();
    sample("rst_div_done", ZERO);

    // Exception held pending by ibus_stall; other inputs ignored meanwhile.
    tick();
    idle();
    mem_excp = 1; ibus_stall = 1;
    sample("xp_enter", ev(5'b0, F_XP, 1, 0, 0, 2'b00, 2'b00));
    tick();
    mem_excp = 0; dbus_stall = 1;
    sample("xp_hold1", ev(5'b0, F_XP, 1, 0, 0, 2'b00, 2'b00));
    tick();
    sample("xp_hold2", ev(5'b0, F_XP, 1, 0, 0, 2'b00, 2'b00));
    tick();
    ibus_stall = 0;
    sample("xp_exit", ev(5'b0, F_XP, 1, 0, 0, 2'b00, 2'b00));
    tick();
    dbus_stall = 0;
    sample("xp_done", ZERO);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
